// File: rtl/imc_ctrl_pkg.sv
// Shared types and constants for the in-memory-compute macro sequencer.
// Pin bundle layout mirrors the macro's registered control interface.
package imc_ctrl_pkg;

  localparam int ROWS       = 16;
  localparam int DUMMY_ROWS = 8;
  localparam int ADC_BITS   = 4;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_MAC   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_PRE,
    S_EVAL,
    S_SENSE,
    S_CAPTURE,
    S_RESP
  } state_e;

  typedef struct packed {
    logic [ROWS-1:0]       wwl;
    logic [DUMMY_ROWS-1:0] wwld;
    logic [ROWS-1:0]       rwl;
    logic [ROWS-1:0]       rwlb;
    logic [ROWS-1:0]       din;
    logic                  we;
    logic                  pre_sram;
    logic                  pre_vlsa;
    logic                  pre_clsa;
    logic                  pre_a;
    logic                  saen;
    logic                  vclp;
    logic                  en;
  } macro_pins_t;

  function automatic logic [ROWS-1:0] row_onehot(input logic [3:0] idx);
    row_onehot      = '0;
    row_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/imc_phase_timer.sv
// Loadable 4-bit down-counter shared by every timed sequencer state.
// o_done is high while the count sits at zero.
module imc_phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  output logic       o_done
);

  logic [3:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != 4'd0) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_done = (r_count == 4'd0);

endmodule

// File: rtl/imc_macro_ctrl.sv
// Sequencer turning valid/ready commands into SRAM IMC macro pin timing.
// Macro pins are registered from the next state so strobes move one edge after a decision.
module imc_macro_ctrl
  import imc_ctrl_pkg::*;
#(
  parameter int PRE_CYCLES = 2,
  parameter int WL_CYCLES  = 2,
  parameter int SA_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [4:0]            cmd_addr,
  input  logic [15:0]           cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [63:0]           rsp_data,
  output logic                  rsp_err,
  output logic [ROWS-1:0]       WWL,
  output logic [DUMMY_ROWS-1:0] WWLD,
  output logic [ROWS-1:0]       RWL,
  output logic [ROWS-1:0]       RWLB,
  output logic [ROWS-1:0]       Din,
  output logic                  WE,
  output logic                  PRE_SRAM,
  output logic                  PRE_VLSA,
  output logic                  PRE_CLSA,
  output logic                  PRE_A,
  output logic                  SAEN,
  output logic                  VCLP,
  output logic                  EN,
  input  logic [ROWS-1:0]       SA_OUT,
  input  logic [ADC_BITS-1:0]   ADC0_OUT,
  input  logic [ADC_BITS-1:0]   ADC1_OUT,
  input  logic [ADC_BITS-1:0]   ADC2_OUT,
  input  logic [ADC_BITS-1:0]   ADC3_OUT,
  input  logic [ADC_BITS-1:0]   ADC4_OUT,
  input  logic [ADC_BITS-1:0]   ADC5_OUT,
  input  logic [ADC_BITS-1:0]   ADC6_OUT,
  input  logic [ADC_BITS-1:0]   ADC7_OUT,
  input  logic [ADC_BITS-1:0]   ADC8_OUT,
  input  logic [ADC_BITS-1:0]   ADC9_OUT,
  input  logic [ADC_BITS-1:0]   ADC10_OUT,
  input  logic [ADC_BITS-1:0]   ADC11_OUT,
  input  logic [ADC_BITS-1:0]   ADC12_OUT,
  input  logic [ADC_BITS-1:0]   ADC13_OUT,
  input  logic [ADC_BITS-1:0]   ADC14_OUT,
  input  logic [ADC_BITS-1:0]   ADC15_OUT
);

  localparam logic [3:0] PRE_LOAD = 4'(PRE_CYCLES - 1);
  localparam logic [3:0] WL_LOAD  = 4'(WL_CYCLES - 1);
  localparam logic [3:0] SA_LOAD  = 4'(SA_CYCLES - 1);

  state_e      r_state, w_next_state;
  op_e         r_op, w_op;
  logic [4:0]  r_addr, w_addr;
  logic [15:0] r_data, w_data;
  logic        r_started;
  logic        r_rsp_valid;
  logic [63:0] r_rsp_data;
  logic        r_rsp_err;
  macro_pins_t r_pins, w_pins;
  logic        w_accept;
  logic        w_is_mac;
  logic        w_load;
  logic [3:0]  w_load_val;
  logic        w_timer_done;
  logic [63:0] w_adc_word;

  // r_started keeps cmd_ready low until the first edge after reset release.
  assign cmd_ready = r_started && (r_state == S_IDLE) && !r_rsp_valid;
  assign w_accept  = cmd_valid && cmd_ready;

  // Pin decode looks at the incoming command on the accept edge, the latched copy afterwards.
  assign w_op     = w_accept ? op_e'(cmd_op) : r_op;
  assign w_addr   = w_accept ? cmd_addr : r_addr;
  assign w_data   = w_accept ? cmd_data : r_data;
  assign w_is_mac = (w_op == OP_MAC);

  assign w_adc_word = {ADC15_OUT, ADC14_OUT, ADC13_OUT, ADC12_OUT,
                       ADC11_OUT, ADC10_OUT, ADC9_OUT,  ADC8_OUT,
                       ADC7_OUT,  ADC6_OUT,  ADC5_OUT,  ADC4_OUT,
                       ADC3_OUT,  ADC2_OUT,  ADC1_OUT,  ADC0_OUT};

  imc_phase_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_timer_done)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (op_e'(cmd_op))
            OP_WRITE:        w_next_state = S_WRITE;
            OP_READ, OP_MAC: w_next_state = S_PRE;
            default:         w_next_state = S_RESP;
          endcase
        end
      end
      S_WRITE:   if (w_timer_done) w_next_state = S_IDLE;
      S_PRE:     if (w_timer_done) w_next_state = S_EVAL;
      S_EVAL:    if (w_timer_done) w_next_state = S_SENSE;
      S_SENSE:   if (w_timer_done) w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = S_RESP;
      S_RESP:    if (rsp_ready) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_load     = (w_next_state != r_state);
    w_load_val = 4'd0;
    case (w_next_state)
      S_WRITE, S_EVAL: w_load_val = WL_LOAD;
      S_PRE:           w_load_val = PRE_LOAD;
      S_SENSE:         w_load_val = SA_LOAD;
      default:         w_load_val = 4'd0;
    endcase
  end

  always_comb begin
    w_pins = '0;
    case (w_next_state)
      S_WRITE: begin
        w_pins.we  = 1'b1;
        w_pins.din = w_data;
        if (w_addr[4]) w_pins.wwld = DUMMY_ROWS'(1) << w_addr[2:0];
        else           w_pins.wwl  = row_onehot(w_addr[3:0]);
      end
      S_PRE: begin
        w_pins.pre_sram = 1'b1;
        w_pins.pre_vlsa = !w_is_mac;
        w_pins.pre_clsa = w_is_mac;
        w_pins.pre_a    = w_is_mac;
      end
      S_EVAL, S_SENSE: begin
        // A dummy-row READ leaves RWL at zero, which senses dummy row 0.
        if (w_is_mac) begin
          w_pins.rwl  = w_data;
          w_pins.rwlb = ~w_data;
          w_pins.vclp = 1'b1;
        end else if (!w_addr[4]) begin
          w_pins.rwl = row_onehot(w_addr[3:0]);
        end
        if (w_next_state == S_SENSE) begin
          w_pins.saen = !w_is_mac;
          w_pins.en   = w_is_mac;
        end
      end
      S_CAPTURE: begin
        w_pins.saen = !w_is_mac;
        w_pins.en   = w_is_mac;
        w_pins.vclp = w_is_mac;
      end
      default: w_pins = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_WRITE;
      r_addr      <= '0;
      r_data      <= '0;
      r_started   <= 1'b0;
      r_pins      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_started   <= 1'b1;
      r_state     <= w_next_state;
      r_pins      <= w_pins;
      r_rsp_valid <= (w_next_state == S_RESP);
      if (w_accept) begin
        r_op       <= w_op;
        r_addr     <= cmd_addr;
        r_data     <= cmd_data;
        r_rsp_data <= '0;
        r_rsp_err  <= (w_op == OP_RSVD);
      end else if (r_state == S_CAPTURE) begin
        r_rsp_data <= (r_op == OP_MAC) ? w_adc_word : {48'b0, SA_OUT};
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign WWL       = r_pins.wwl;
  assign WWLD      = r_pins.wwld;
  assign RWL       = r_pins.rwl;
  assign RWLB      = r_pins.rwlb;
  assign Din       = r_pins.din;
  assign WE        = r_pins.we;
  assign PRE_SRAM  = r_pins.pre_sram;
  assign PRE_VLSA  = r_pins.pre_vlsa;
  assign PRE_CLSA  = r_pins.pre_clsa;
  assign PRE_A     = r_pins.pre_a;
  assign SAEN      = r_pins.saen;
  assign VCLP      = r_pins.vclp;
  assign EN        = r_pins.en;

endmodule

// File: tb/tb_imc_macro_ctrl.sv
// Directed bench for imc_macro_ctrl: per-cycle pin traces, a command vector table,
// response backpressure and a reset dropped into the middle of a MAC.
module tb_imc_macro_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic [63:0] rsp_data;
  logic [15:0] WWL, RWL, RWLB, Din, sa;
  logic [7:0]  WWLD;
  logic        WE, PRE_SRAM, PRE_VLSA, PRE_CLSA, PRE_A, SAEN, VCLP, EN;
  logic [3:0]  adc [16];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imc_macro_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .WWL(WWL), .WWLD(WWLD), .RWL(RWL), .RWLB(RWLB), .Din(Din), .WE(WE),
    .PRE_SRAM(PRE_SRAM), .PRE_VLSA(PRE_VLSA), .PRE_CLSA(PRE_CLSA), .PRE_A(PRE_A),
    .SAEN(SAEN), .VCLP(VCLP), .EN(EN), .SA_OUT(sa),
    .ADC0_OUT(adc[0]),   .ADC1_OUT(adc[1]),   .ADC2_OUT(adc[2]),   .ADC3_OUT(adc[3]),
    .ADC4_OUT(adc[4]),   .ADC5_OUT(adc[5]),   .ADC6_OUT(adc[6]),   .ADC7_OUT(adc[7]),
    .ADC8_OUT(adc[8]),   .ADC9_OUT(adc[9]),   .ADC10_OUT(adc[10]), .ADC11_OUT(adc[11]),
    .ADC12_OUT(adc[12]), .ADC13_OUT(adc[13]), .ADC14_OUT(adc[14]), .ADC15_OUT(adc[15])
  );

  // Strobe byte order: PRE_SRAM PRE_VLSA PRE_CLSA PRE_A SAEN VCLP EN WE
  typedef struct packed {
    logic [7:0]  stb;
    logic [15:0] wwl;
    logic [7:0]  wwld;
    logic [15:0] din;
    logic [15:0] rwl;
    logic [15:0] rwlb;
    logic        rv;
    logic        cr;
  } snap_t;

  localparam logic [7:0] B_PRE_R  = 8'b1100_0000;
  localparam logic [7:0] B_PRE_M  = 8'b1011_0000;
  localparam logic [7:0] B_SAEN   = 8'b0000_1000;
  localparam logic [7:0] B_VCLP   = 8'b0000_0100;
  localparam logic [7:0] B_MSENSE = 8'b0000_0110;
  localparam logic [7:0] B_WE     = 8'b0000_0001;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  addr;
    logic [15:0] data;
    logic [15:0] sa;
    logic        adc_rev;
    logic [63:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t  vecs [6];
  snap_t exp_tr [1:8];

  function automatic snap_t snap();
    snap_t s;
    s.stb  = {PRE_SRAM, PRE_VLSA, PRE_CLSA, PRE_A, SAEN, VCLP, EN, WE};
    s.wwl  = WWL;
    s.wwld = WWLD;
    s.din  = Din;
    s.rwl  = RWL;
    s.rwlb = RWLB;
    s.rv   = rsp_valid;
    s.cr   = cmd_ready;
    return s;
  endfunction

  function automatic snap_t mk(input logic [7:0] stb, input logic [15:0] wwl,
                               input logic [7:0] wwld, input logic [15:0] din,
                               input logic [15:0] rwl, input logic [15:0] rwlb,
                               input logic rv, input logic cr);
    snap_t s;
    s = '{stb, wwl, wwld, din, rwl, rwlb, rv, cr};
    return s;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_adc(input logic rev);
    for (int k = 0; k < 16; k++) adc[k] = rev ? 4'(15 - k) : 4'(k);
  endtask

  // Presents a command and returns just after the accepting edge (start of cycle 1).
  task automatic send(input logic [1:0] op, input logic [4:0] addr, input logic [15:0] data);
    int n = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_before_accept", 128'(cmd_ready), 128'(1'b1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic trace(input int first, input int last, input string tag);
    for (int k = first; k <= last; k++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", tag, k), 128'(snap()), 128'(exp_tr[k]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  got;
    bit  any_rv;

    vecs[0] = '{2'd1, 5'h0F, 16'h0000, 16'hBEEF, 1'b0, 64'h0000_0000_0000_BEEF, 1'b0, 7};
    vecs[1] = '{2'd1, 5'h13, 16'h0000, 16'h00C3, 1'b0, 64'h0000_0000_0000_00C3, 1'b0, 7};
    vecs[2] = '{2'd2, 5'h00, 16'h00FF, 16'h0000, 1'b0, 64'hFEDC_BA98_7654_3210, 1'b0, 7};
    vecs[3] = '{2'd2, 5'h00, 16'hA5A5, 16'h0000, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 7};
    vecs[4] = '{2'd3, 5'h01, 16'hFFFF, 16'hFFFF, 1'b0, 64'h0,                   1'b1, 1};
    vecs[5] = '{2'd1, 5'h00, 16'h0000, 16'hFFFF, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0, 7};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b1; sa = '0;
    set_adc(1'b0);

    // Reset state and release timing.
    #3;
    check("reset_pins", 128'(snap()), 128'(mk('0, '0, '0, '0, '0, '0, 1'b0, 1'b0)));
    check("reset_rsp", 128'({rsp_err, rsp_data}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_at_release", 128'(cmd_ready), 128'(1'b0));
    @(negedge clk);
    check("ready_after_release", 128'(cmd_ready), 128'(1'b1));

    // WRITE addr 5.
    exp_tr[1] = mk(B_WE, 16'h0020, '0, 16'hA5A5, '0, '0, 1'b0, 1'b0);
    exp_tr[2] = exp_tr[1];
    exp_tr[3] = mk('0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
    exp_tr[4] = exp_tr[3];
    send(2'd0, 5'd5, 16'hA5A5);
    trace(1, 4, "write5");

    // READ addr 3.
    sa = 16'h1234;
    exp_tr[1] = mk(B_PRE_R, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    exp_tr[2] = exp_tr[1];
    exp_tr[3] = mk('0, '0, '0, '0, 16'h0008, '0, 1'b0, 1'b0);
    exp_tr[4] = exp_tr[3];
    exp_tr[5] = mk(B_SAEN, '0, '0, '0, 16'h0008, '0, 1'b0, 1'b0);
    exp_tr[6] = mk(B_SAEN, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    exp_tr[7] = mk('0, '0, '0, '0, '0, '0, 1'b1, 1'b0);
    exp_tr[8] = mk('0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
    send(2'd1, 5'd3, 16'h0000);
    trace(1, 7, "read3");
    check("read3_data", 128'({rsp_err, rsp_data}), 128'({1'b0, 64'h1234}));
    trace(8, 8, "read3");

    // MAC data 0x00FF with ADCk = k.
    set_adc(1'b0);
    exp_tr[1] = mk(B_PRE_M, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    exp_tr[2] = exp_tr[1];
    exp_tr[3] = mk(B_VCLP, '0, '0, '0, 16'h00FF, 16'hFF00, 1'b0, 1'b0);
    exp_tr[4] = exp_tr[3];
    exp_tr[5] = mk(B_MSENSE, '0, '0, '0, 16'h00FF, 16'hFF00, 1'b0, 1'b0);
    exp_tr[6] = mk(B_MSENSE, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    exp_tr[7] = mk('0, '0, '0, '0, '0, '0, 1'b1, 1'b0);
    exp_tr[8] = mk('0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
    send(2'd2, 5'd0, 16'h00FF);
    trace(1, 7, "mac");
    check("mac_data", 128'(rsp_data), 128'(64'hFEDC_BA98_7654_3210));
    trace(8, 8, "mac");

    // Command vector table: response latency, data and error flag.
    for (int i = 0; i < 6; i++) begin
      sa = vecs[i].sa;
      set_adc(vecs[i].adc_rev);
      send(vecs[i].op, vecs[i].addr, vecs[i].data);
      lat = 0;
      got = 1'b0;
      for (int k = 1; k <= 20 && !got; k++) begin
        @(negedge clk);
        if (rsp_valid) begin
          got = 1'b1;
          lat = k;
        end
      end
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(vecs[i].exp_lat));
      check($sformatf("vec%0d_data", i), 128'(rsp_data), 128'(vecs[i].exp_data));
      check($sformatf("vec%0d_err", i), 128'(rsp_err), 128'(vecs[i].exp_err));
    end

    // WRITE to dummy address 0x12.
    exp_tr[1] = mk(B_WE, '0, 8'h04, 16'h0F0F, '0, '0, 1'b0, 1'b0);
    exp_tr[2] = exp_tr[1];
    exp_tr[3] = mk('0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
    send(2'd0, 5'h12, 16'h0F0F);
    trace(1, 3, "write_dummy");

    // Response backpressure: rsp_ready low for five RESP cycles.
    rsp_ready = 1'b0;
    sa = 16'h5A5A;
    send(2'd1, 5'd7, 16'h0000);
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        lat = k;
      end
    end
    check("bp_latency", 128'(lat), 128'(7));
    check("bp_hold0", 128'({rsp_valid, cmd_ready, rsp_data}), 128'({1'b1, 1'b0, 64'h5A5A}));
    sa = 16'h0000;
    for (int h = 1; h <= 4; h++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", h), 128'({rsp_valid, cmd_ready, rsp_data}),
            128'({1'b1, 1'b0, 64'h5A5A}));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 5'd1; cmd_data = 16'h1111;
    @(negedge clk);
    check("bp_release_cycle", 128'({rsp_valid, cmd_ready}), 128'(2'b10));
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_cycle", 128'({rsp_valid, cmd_ready}), 128'(2'b01));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_next_accepted", 128'(snap()),
          128'(mk(B_WE, 16'h0002, '0, 16'h1111, '0, '0, 1'b0, 1'b0)));

    // Reset asserted during MAC EVAL.
    send(2'd2, 5'd0, 16'h3C3C);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rst_mac_eval", 128'(snap()), 128'(mk(B_VCLP, '0, '0, '0, 16'h3C3C, 16'hC3C3, 1'b0, 1'b0)));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_pins", 128'(snap()), 128'(mk('0, '0, '0, '0, '0, '0, 1'b0, 1'b0)));
    check("rst_async_rsp", 128'({rsp_err, rsp_data}), 128'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready_at_release", 128'(cmd_ready), 128'(1'b0));
    @(negedge clk);
    check("rst_ready_after_release", 128'(cmd_ready), 128'(1'b1));
    any_rv = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) any_rv = 1'b1;
    end
    check("rst_no_response", 128'(any_rv), 128'(1'b0));
    check("rst_idle_pins", 128'(snap()), 128'(mk('0, '0, '0, '0, '0, '0, 1'b0, 1'b1)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
